// File: rtl/ex_shift_pipe_if.sv
// Issue/writeback handshake bundle for ex_shift_pipe.
// The slave modport is the shifter side; the master modport is the issue/writeback side.
interface ex_shift_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic              iValid;
    logic              oReady;
    logic [1:0]        iOp;
    logic [XLEN-1:0]   iSrc;
    logic [SHW-1:0]    iShamt;
    logic [TAG_W-1:0]  iTag;
    logic              iFlush;
    logic              oValid;
    logic              iReady;
    logic [XLEN-1:0]   oResult;
    logic [TAG_W-1:0]  oTag;

    modport slave (
        input  iValid, iOp, iSrc, iShamt, iTag, iFlush, iReady,
        output oReady, oValid, oResult, oTag
    );

    modport master (
        output iValid, iOp, iSrc, iShamt, iTag, iFlush, iReady,
        input  oReady, oValid, oResult, oTag
    );
endinterface

// File: rtl/ex_shift_pipe.sv
// Pipelined SLL/SRL/SRA shifter with valid/ready handshake, tag and flush.
// Define SHIFT_ROTATE_EN to make op 2'b11 a rotate right; otherwise op 2'b11 yields 0.
module ex_shift_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    ex_shift_pipe_if.slave     bus
);
    localparam int unsigned L   = $clog2(XLEN);
    localparam int          LI  = int'(L);
    localparam int          STG = int'(STAGES);
    localparam logic [XLEN-1:0] ONES = '1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [1:0]        op;
        logic              fill;
        logic [L-1:0]      shamt;
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   data;
    } stage_t;

    stage_t r_pipe [STAGES];
    stage_t w_next [STAGES];
    stage_t w_head;
    logic   w_adv;

    // Apply only the shamt bits owned by stage stg: bit b lives in stage floor(b*STAGES/L).
    function automatic logic [XLEN-1:0] f_shift(
        input logic [XLEN-1:0] d,
        input logic [1:0]      op,
        input logic            fill,
        input logic [L-1:0]    sh,
        input int              stg
    );
        logic [XLEN-1:0] res;
        int unsigned     k;
        res = d;
        for (int b = 0; b < LI; b++) begin
            k = 32'd1 << b;
            if (sh[b] && (((b * STG) / LI) == stg)) begin
                case (op)
                    OP_SLL:  res = res << k;
                    OP_SRL:  res = res >> k;
                    OP_SRA:  res = (res >> k) | (fill ? ~(ONES >> k) : '0);
`ifdef SHIFT_ROTATE_EN
                    default: res = (res >> k) | (res << (XLEN - k));
`else
                    default: res = res;
`endif
                endcase
            end
        end
        return res;
    endfunction

    assign w_adv = !r_pipe[STAGES-1].valid | bus.iReady;

    // Entry bundle: SRA fill bit is captured here and travels with the op.
    always_comb begin
        w_head       = '0;
        w_head.valid = bus.iValid;
        w_head.op    = bus.iOp;
        w_head.fill  = bus.iSrc[XLEN-1];
        w_head.shamt = bus.iShamt;
        w_head.tag   = bus.iTag;
`ifdef SHIFT_ROTATE_EN
        w_head.data  = bus.iSrc;
`else
        w_head.data  = (bus.iOp == 2'b11) ? '0 : bus.iSrc;
`endif
    end

    always_comb begin
        for (int g = 0; g < STG; g++) begin
            w_next[g] = '0;
        end
        w_next[0]      = w_head;
        w_next[0].data = f_shift(w_head.data, w_head.op, w_head.fill, w_head.shamt, 0);
        for (int g = 1; g < STG; g++) begin
            w_next[g]      = r_pipe[g-1];
            w_next[g].data = f_shift(r_pipe[g-1].data, r_pipe[g-1].op, r_pipe[g-1].fill,
                                     r_pipe[g-1].shamt, g);
        end
    end

    // Global advance/stall; flush clears every valid bit regardless of stall or accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < STG; g++) begin
                r_pipe[g] <= '0;
            end
        end else if (bus.iFlush) begin
            for (int g = 0; g < STG; g++) begin
                r_pipe[g].valid <= 1'b0;
            end
        end else if (w_adv) begin
            for (int g = 0; g < STG; g++) begin
                r_pipe[g] <= w_next[g];
            end
        end
    end

    assign bus.oReady  = w_adv & !bus.iFlush;
    assign bus.oValid  = r_pipe[STAGES-1].valid;
    assign bus.oResult = r_pipe[STAGES-1].data;
    assign bus.oTag    = r_pipe[STAGES-1].tag;

endmodule
